fc_out_reader: RTL



---
 rtl/fc_pkg.sv | 16 +
 rtl/fc_out_reader_if.sv | 11 +
 rtl/fc_vec_buf.sv | 35 +++
 rtl/fc_out_reader.sv | 88 ++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the fc output reader: FSM states, default element width
// and the index-width helper used by controller and buffer.
package fc_pkg;

    localparam int T_DEFAULT = 16;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fc_out_reader_if.sv
// Element stream from an fc layer output to its reader (valid/ready/data).
interface fc_out_reader_if #(
    parameter int T = 16
);
    logic                valid;
    logic                ready;
    logic signed [T-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fc_vec_buf.sv
// M x T register file: one write port, one registered read port that returns
// zero for indices outside the vector.
module fc_vec_buf #(
    parameter int M  = 6,
    parameter int T  = 16,
    parameter int AW = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic signed [T-1:0] wr_data,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_addr,
    output logic signed [T-1:0] rd_data
);

    // Contents are intentionally left uninitialised on reset.
    logic signed [T-1:0] mem [M];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (int'(rd_addr) < M) ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/fc_out_reader.sv
// Captures one M-element vector from an fc layer, holds it for random-access
// readout until released. Optional running argmax: FC_OUT_READER_ARGMAX_EN.
module fc_out_reader
    import fc_pkg::*;
#(
    parameter  int M  = 6,
    parameter  int T  = T_DEFAULT,
    localparam int AW = idx_width(M)
) (
    input  logic                clk,
    input  logic                reset,
    fc_out_reader_if.slave      in_if,
    output logic                vec_valid,
    input  logic                vec_release,
    input  logic [AW-1:0]       rd_addr,
    input  logic                rd_en,
    output logic signed [T-1:0] rd_data,
`ifdef FC_OUT_READER_ARGMAX_EN
    output logic [AW-1:0]       argmax_idx,
    output logic signed [T-1:0] max_val,
`endif
    output logic [AW-1:0]       wr_idx
);

    state_t state, state_next;
    logic   accept;
    logic   last_elem;

    // in_ready is gated by reset so upstream never handshakes during the reset cycle.
    assign in_if.ready = (state == COLLECT) && !reset;
    assign vec_valid   = (state == HOLD);
    assign accept      = in_if.valid && in_if.ready;
    assign last_elem   = (int'(wr_idx) == M - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (accept && last_elem) state_next = HOLD;
            HOLD:    if (vec_release)         state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx <= '0;
        end else if (accept) begin
            wr_idx <= last_elem ? '0 : wr_idx + AW'(1);
        end
    end

    fc_vec_buf #(
        .M  (M),
        .T  (T),
        .AW (AW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_addr (wr_idx),
        .wr_data (in_if.data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

`ifdef FC_OUT_READER_ARGMAX_EN
    // Strict compare keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (reset) begin
            argmax_idx <= '0;
            max_val    <= '0;
        end else if (accept && ((wr_idx == '0) || (in_if.data > max_val))) begin
            argmax_idx <= wr_idx;
            max_val    <= in_if.data;
        end
    end
`endif

endmodule
